// File: rtl/psram_arb_pkg.sv
// ----------------------------------------------------------------------------
// psram_arb_pkg: shared state encoding and constants for the PSRAM arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package psram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;
  localparam int          CS_W       = 2;

endpackage

`default_nettype wire

// File: rtl/psram_arb_if.sv
// ----------------------------------------------------------------------------
// psram_arb_if: requester-side and controller-side buses of the PSRAM arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface psram_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int CHIP_AW = 23
);
  import psram_arb_pkg::*;

  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ*32-1:0] req_addr_i;
  logic [NUM_REQ*32-1:0] req_wdata_i;
  logic [NUM_REQ*4-1:0]  req_wstrb_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [31:0]           req_rdata_o;
  logic                  req_err_o;

  logic                  mem_valid_o;
  logic [CHIP_AW-1:0]    mem_addr_o;
  logic [CS_W-1:0]       mem_cs_o;
  logic [31:0]           mem_wdata_o;
  logic [3:0]            mem_wstrb_o;
  logic                  mem_ready_i;
  logic [31:0]           mem_rdata_i;

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i, mem_ready_i, mem_rdata_i,
    output req_ready_o, req_rdata_o, req_err_o,
           mem_valid_o, mem_addr_o, mem_cs_o, mem_wdata_o, mem_wstrb_o
  );

  // Requesters and controller side.
  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i, mem_ready_i, mem_rdata_i,
    input  req_ready_o, req_rdata_o, req_err_o,
           mem_valid_o, mem_addr_o, mem_cs_o, mem_wdata_o, mem_wstrb_o
  );

endinterface

`default_nettype wire

// File: rtl/psram_rr_pick.sv
// ----------------------------------------------------------------------------
// psram_rr_pick: combinational round-robin picker, searching from last_i+1.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module psram_rr_pick #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] win_onehot_o,
  output logic [IDX_W-1:0]   win_idx_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    win_onehot_o = '0;
    win_idx_o    = '0;
    found        = 1'b0;
    idx          = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((int'(last_i) + off) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found             = 1'b1;
        win_onehot_o[idx] = 1'b1;
        win_idx_o         = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/psram_arb.sv
// ----------------------------------------------------------------------------
// psram_arb: round-robin arbiter/sequencer for the QSPI PSRAM controller.
// Optional watchdog abort enabled by PSRAM_ARB_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module psram_arb
  import psram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CHIP_AW = 23,
  parameter int NUM_CS  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  psram_arb_if.slave         bus,
  output logic               busy_o,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] win_q, win_d;
  logic [IDX_W-1:0]   win_idx_q, win_idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CHIP_AW-1:0] addr_q, addr_d;
  logic [CS_W-1:0]    cs_q, cs_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        rdata_q, rdata_d;
`ifdef PSRAM_ARB_TIMEOUT_EN
  logic [15:0]        cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_wstrb;
  logic               unused_ok;

  psram_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i        (bus.req_valid_i),
    .last_i       (last_q),
    .win_onehot_o (pick_oh),
    .win_idx_o    (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr  = bus.req_addr_i[32*i +: 32];
        sel_wdata = bus.req_wdata_i[32*i +: 32];
        sel_wstrb = bus.req_wstrb_i[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    win_idx_d = win_idx_q;
    last_d    = last_q;
    addr_d    = addr_q;
    cs_d      = cs_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
`ifdef PSRAM_ARB_TIMEOUT_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req_valid_i) begin
          win_d     = pick_oh;
          win_idx_d = pick_idx;
          addr_d    = sel_addr[CHIP_AW-1:0];
          cs_d      = sel_addr[CHIP_AW +: CS_W];
          wdata_d   = sel_wdata;
          wstrb_d   = sel_wstrb;
          state_d   = GRANT;
        end
      end
      GRANT: state_d = BUSY;
      BUSY: begin
        // A controller response wins over a simultaneous watchdog expiry.
        if (bus.mem_ready_i) begin
          rdata_d = bus.mem_rdata_i;
          last_d  = win_idx_q;
          state_d = DONE;
`ifdef PSRAM_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef PSRAM_ARB_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT - 1)) begin
          rdata_d = ABORT_DATA;
          err_d   = 1'b1;
          last_d  = win_idx_q;
          state_d = DONE;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef PSRAM_ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == GRANT) begin
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      win_q     <= '0;
      win_idx_q <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      addr_q    <= '0;
      cs_q      <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
`ifdef PSRAM_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      win_idx_q <= win_idx_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
`ifdef PSRAM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.mem_valid_o = (state_q == GRANT) || (state_q == BUSY);
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_cs_o    = cs_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_wstrb_o = wstrb_q;
  assign bus.req_ready_o = (state_q == DONE) ? win_q : '0;
  assign bus.req_rdata_o = rdata_q;
  assign busy_o          = (state_q != IDLE);
  assign grant_o         = (state_q != IDLE) ? win_q : '0;

  // Upper address bits alias across the chip-select window.
`ifdef PSRAM_ARB_TIMEOUT_EN
  assign bus.req_err_o = (state_q == DONE) && err_q;
  assign unused_ok     = ^{sel_addr[31:CHIP_AW+CS_W], 32'(NUM_CS)};
`else
  assign bus.req_err_o = 1'b0;
  assign unused_ok     = ^{sel_addr[31:CHIP_AW+CS_W], 32'(NUM_CS), 32'(TIMEOUT)};
`endif

endmodule

`default_nettype wire

// File: tb/tb_psram_arb.sv
// ----------------------------------------------------------------------------
// tb_psram_arb: directed self-checking bench for psram_arb.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_psram_arb;

  localparam int NUM_REQ = 3;
  localparam int CHIP_AW = 23;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [2:0] grant;
  int         checks   = 0;
  int         failures = 0;
  int         exp_order [6] = '{0, 1, 2, 0, 1, 2};

  always #5 clk = ~clk;

  psram_arb_if #(.NUM_REQ(NUM_REQ), .CHIP_AW(CHIP_AW)) bus ();

  psram_arb #(
    .NUM_REQ (NUM_REQ),
    .CHIP_AW (CHIP_AW),
    .NUM_CS  (4),
    .TIMEOUT (16)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus),
    .busy_o  (busy),
    .grant_o (grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_mem_valid(input string tag);
    int n = 0;
    while (bus.mem_valid_o !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.mem_valid_o), 32'd1);
  endtask

  initial begin
    int n;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_wstrb_i = '0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;

    // Reset state
    repeat (2) tick();
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check("rst_mem_valid", 32'(bus.mem_valid_o), 32'd0);
    check("rst_busy",      32'(busy),            32'd0);
    check("rst_grant",     32'(grant),           32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr_o),  32'd0);
    check("rst_rdata",     bus.req_rdata_o,      32'd0);

    // Single read from requester 1, controller ready at cycle 4
    rst_n           = 1'b1;
    bus.req_valid_i = 3'b010;
    bus.req_addr_i  = {32'h0, 32'h0180_0010, 32'h0};
    tick();
    check("rd_mem_valid_c1", 32'(bus.mem_valid_o), 32'd1);
    check("rd_grant_c1",     32'(grant),           32'b010);
    check("rd_cs",           32'(bus.mem_cs_o),    32'd3);
    check("rd_addr",         32'(bus.mem_addr_o),  32'h10);
    check("rd_wstrb",        32'(bus.mem_wstrb_o), 32'd0);
    check("rd_busy",         32'(busy),            32'd1);
    tick();
    tick();
    check("rd_mem_valid_c3", 32'(bus.mem_valid_o), 32'd1);
    tick();
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h1234_5678;
    check("rd_no_ready_c4",  32'(bus.req_ready_o), 32'd0);
    tick();
    bus.mem_ready_i = 1'b0;
    check("rd_req_ready_c5", 32'(bus.req_ready_o), 32'b010);
    check("rd_rdata_c5",     bus.req_rdata_o,      32'h1234_5678);
    check("rd_mem_valid_c5", 32'(bus.mem_valid_o), 32'd0);
    check("rd_err_c5",       32'(bus.req_err_o),   32'd0);
    bus.req_valid_i = 3'b000;
    tick();
    check("rd_idle_busy",    32'(busy),            32'd0);
    check("rd_idle_ready",   32'(bus.req_ready_o), 32'd0);

    // Round robin with all requesters continuously valid after reset
    rst_n = 1'b0;
    tick();
    rst_n           = 1'b1;
    bus.req_valid_i = 3'b111;
    bus.req_addr_i  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    for (int k = 0; k < 6; k++) begin
      wait_mem_valid("rr_mem_valid");
      check("rr_grant", 32'(grant), 32'(1) << exp_order[k]);
      tick();
      bus.mem_ready_i = 1'b1;
      bus.mem_rdata_i = 32'hC0DE_0000 + 32'(k);
      tick();
      bus.mem_ready_i = 1'b0;
      check("rr_req_ready", 32'(bus.req_ready_o), 32'(1) << exp_order[k]);
      check("rr_rdata",     bus.req_rdata_o,      32'hC0DE_0000 + 32'(k));
      tick();
    end
    bus.req_valid_i = 3'b000;

    // Write from requester 2, fields held through BUSY
    bus.req_valid_i = 3'b100;
    bus.req_addr_i  = {32'h0000_0400, 32'h0, 32'h0};
    bus.req_wdata_i = {32'hAABB_CCDD, 32'h0, 32'h0};
    bus.req_wstrb_i = {4'b0011, 4'b0000, 4'b0000};
    wait_mem_valid("wr_mem_valid");
    check("wr_grant", 32'(grant),           32'b100);
    check("wr_cs",    32'(bus.mem_cs_o),    32'd0);
    check("wr_addr",  32'(bus.mem_addr_o),  32'h400);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wr_hold_valid", 32'(bus.mem_valid_o), 32'd1);
      check("wr_hold_wstrb", 32'(bus.mem_wstrb_o), 32'b0011);
      check("wr_hold_wdata", bus.mem_wdata_o,      32'hAABB_CCDD);
    end
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h0;
    tick();
    bus.mem_ready_i = 1'b0;
    check("wr_req_ready", 32'(bus.req_ready_o), 32'b100);
    check("wr_err",       32'(bus.req_err_o),   32'd0);
    bus.req_valid_i = 3'b000;
    bus.req_wstrb_i = '0;
    tick();

    // mem_ready in IDLE is ignored
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus.mem_ready_i = 1'b0;
    check("idle_rdy_req_ready", 32'(bus.req_ready_o), 32'd0);
    check("idle_rdy_busy",      32'(busy),            32'd0);
    check("idle_rdy_mem_valid", 32'(bus.mem_valid_o), 32'd0);
    tick();
    check("idle_rdy_busy2",     32'(busy),            32'd0);

    // Complete one for requester 0, then reset while requester 1 is in BUSY
    bus.req_valid_i = 3'b001;
    bus.req_addr_i  = {32'h0000_0030, 32'h0000_0020, 32'h0080_0000};
    wait_mem_valid("pre_mem_valid");
    check("pre_grant", 32'(grant), 32'b001);
    tick();
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h0000_0077;
    tick();
    bus.mem_ready_i = 1'b0;
    check("pre_req_ready", 32'(bus.req_ready_o), 32'b001);
    bus.req_valid_i = 3'b010;
    tick();
    wait_mem_valid("mid_mem_valid");
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",      32'(busy),            32'd0);
    check("arst_mem_valid", 32'(bus.mem_valid_o), 32'd0);
    check("arst_grant",     32'(grant),           32'd0);
    check("arst_mem_addr",  32'(bus.mem_addr_o),  32'd0);
    check("arst_mem_cs",    32'(bus.mem_cs_o),    32'd0);
    check("arst_req_ready", 32'(bus.req_ready_o), 32'd0);
    tick();
    bus.req_valid_i = 3'b011;
    rst_n           = 1'b1;
    wait_mem_valid("post_rst_mem_valid");
    check("post_rst_grant", 32'(grant), 32'b001);

`ifdef PSRAM_ARB_TIMEOUT_EN
    // Controller never answers: watchdog aborts after 16 BUSY cycles
    n = 0;
    while (bus.mem_valid_o === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("to_busy_cycles", 32'(n - 1),           32'd16);
    check("to_req_ready",   32'(bus.req_ready_o), 32'b001);
    check("to_rdata",       bus.req_rdata_o,      32'hDEAD_BEEF);
    check("to_err",         32'(bus.req_err_o),   32'd1);
`else
    n = 0;
    tick();
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h0000_0055;
    tick();
    bus.mem_ready_i = 1'b0;
    check("r0_req_ready", 32'(bus.req_ready_o), 32'b001);
    check("r0_rdata",     bus.req_rdata_o,      32'h0000_0055);
    check("r0_err",       32'(bus.req_err_o),   32'd0);
`endif
    bus.req_valid_i = 3'b010;
    wait_mem_valid("next_mem_valid");
    check("next_grant", 32'(grant), 32'b010);
    tick();
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h600D_F00D;
    tick();
    bus.mem_ready_i = 1'b0;
    check("next_req_ready", 32'(bus.req_ready_o), 32'b010);
    check("next_rdata",     bus.req_rdata_o,      32'h600D_F00D);
    check("next_err",       32'(bus.req_err_o),   32'd0);
    bus.req_valid_i = 3'b000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/psram_arb.md
# psram_arb

Multi-requester arbiter and sequencer for the single QSPI PSRAM controller core behind the `psram_*` pads. It serves up to NUM_REQ masters: core instruction fetch, core data and DMA. Requests are granted round-robin, one transaction at a time. The flat byte address is decoded into one of four chip selects (`psram_nss0..3`) plus an in-chip address. An optional watchdog aborts a transaction when the controller never responds.

## Interface
- NUM_REQ, 3: number of requesters (2..4).
- CHIP_AW, 23: in-chip byte-address width (8 MiB per chip).
- NUM_CS, 4: number of PSRAM chip selects.
- TIMEOUT, 1024: watchdog limit in clk_i cycles (1..65535); used only with PSRAM_ARB_TIMEOUT_EN.
- clk_i  in  1  system clock; the only clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_addr_i  in  NUM_REQ*32  byte addresses; requester i occupies slice [32*i+:32].
- req_wdata_i  in  NUM_REQ*32  write data.
- req_wstrb_i  in  NUM_REQ*4  byte strobes; all zero means read.
- req_ready_o  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_rdata_o  out  32  read data, shared by all requesters; valid while any req_ready_o bit is high.
- req_err_o  out  1  with req_ready_o: transaction aborted by timeout.
- mem_valid_o  out  1  request to the controller.
- mem_addr_o  out  CHIP_AW  in-chip byte address.
- mem_cs_o  out  2  chip index 0..NUM_CS-1.
- mem_wdata_o  out  32  write data to the controller.
- mem_wstrb_o  out  4  byte strobes to the controller.
- mem_ready_i  in  1  controller completion pulse.
- mem_rdata_i  in  32  controller read data, valid with mem_ready_i.
- busy_o  out  1  state is not IDLE.
- grant_o  out  NUM_REQ  one-hot current owner; zero in IDLE.

## Operation
- Handshake rules: valid/ready in picorv32 style. A requester holds valid, addr, wdata and wstrb stable until its req_ready_o pulse, then drops valid on the next edge. Dropping valid early is illegal and not checked.
- State machine: IDLE, GRANT, BUSY, DONE.
- IDLE: if any req_valid_i is set, choose the winner round-robin, searching from last_grant+1 modulo NUM_REQ. Register the winner's fields, then go to GRANT.
- GRANT: assert mem_valid_o with the registered fields, then go to BUSY.
- BUSY: hold mem_valid_o and all mem_* fields stable. On mem_ready_i: capture mem_rdata_i, drop mem_valid_o, update last_grant to the winner, go to DONE.
- DONE: pulse req_ready_o[winner] for one cycle with the captured rdata, then go to IDLE.
- DONE exists so the requester's still-high valid is never re-arbitrated.
- Address decode: mem_addr_o = addr[CHIP_AW-1:0]; mem_cs_o = addr[CHIP_AW+1:CHIP_AW]. Higher address bits are ignored; they alias.
- mem_ready_i outside BUSY is ignored.
- A request arriving while the arbiter is busy waits; requests are not queued beyond the requester's held valid.
- Reset mid-operation: return to IDLE immediately. The controller's outstanding transaction is abandoned; the controller is reset by the same rst_n_i.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - last_grant = NUM_REQ-1, so requester 0 wins first;
  - watchdog counter 0.
- Cycle numbering, request seen in IDLE at cycle 0:
  - cycle 1: mem_valid_o asserted.
  - cycle k: controller asserts mem_ready_i.
  - cycle k+1: mem_valid_o low; req_ready_o high.
- Minimum request-to-ready latency is 3 cycles, when mem_ready_i arrives at cycle 2.
- A new arbitration can start at cycle k+2.
- Back-to-back throughput is one transaction per (controller latency + 3) cycles.
- grant_o is asserted from GRANT through DONE.

## Configuration
- PSRAM_ARB_TIMEOUT_EN defined:
  - a 16-bit counter clears on entry to GRANT and increments each BUSY cycle;
  - if it reaches TIMEOUT before mem_ready_i: drop mem_valid_o, go to DONE with rdata = 32'hDEAD_BEEF and req_err_o = 1 for the DONE cycle;
  - mem_ready_i in the same cycle as expiry takes precedence (normal completion).
- PSRAM_ARB_TIMEOUT_EN not defined: BUSY waits indefinitely, no counter is built, and req_err_o is tied 0.

## Structure
- Package psram_arb_pkg holds the state encoding (IDLE=0, GRANT=1, BUSY=2, DONE=3), the abort data constant 32'hDEAD_BEEF and the CS field width.
- One sub-module: psram_rr_pick, a combinational round-robin priority picker. Inputs: request vector and last_grant. Outputs: one-hot winner and winner index.
- FSM, field registers and watchdog live in psram_arb.

## Test plan
- Single read from requester 1 at address 0x0180_0010, controller ready at cycle 4 with 0x1234_5678 -> mem_cs_o=3, mem_addr_o=0x00_0010, mem_wstrb_o=0; req_ready_o=3'b010 at cycle 5 with rdata 0x1234_5678.
- All three requesters valid continuously after reset, each issuing repeated reads -> grant order 0,1,2,0,1,2; no requester is granted twice in a row.
- Write from requester 2 with wstrb=4'b0011 and wdata=0xAABB_CCDD -> mem_wstrb_o and mem_wdata_o held stable through BUSY; req_err_o=0.
- With PSRAM_ARB_TIMEOUT_EN and TIMEOUT=16, controller never ready -> mem_valid_o drops after 16 BUSY cycles; req_ready_o pulses with rdata 0xDEAD_BEEF and req_err_o=1; the next requester is then served normally.
- rst_n_i asserted in BUSY -> all outputs 0 asynchronously; after release, requester 0 is granted first.
- mem_ready_i pulsed while in IDLE -> ignored: no req_ready_o and no state change.
